// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard sequencer.
// State codes, latency defaults and the per-source hazard compare.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_STALL = 2'd1,
    S_REQ   = 2'd2
  } state_t;

  localparam logic [1:0] TUSE_NONE = 2'd3;
  localparam logic [4:0] REG_ZERO  = 5'd0;
  localparam int MULT_LAT_D = 5;
  localparam int DIV_LAT_D  = 10;

  function automatic logic src_hazard(
    input logic [4:0] src,
    input logic [1:0] tuse,
    input logic [4:0] wa,
    input logic [1:0] tnew
  );
    return (src != REG_ZERO) &&
           (tuse != TUSE_NONE) &&
           (src == wa) &&
           (tuse < tnew);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_md_busy_timer.sv
// MDU busy countdown for the hazard sequencer.
// Busy covers the start cycle plus the remaining latency.
module md_busy_timer
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_D,
  parameter int DIV_LAT  = DIV_LAT_D,
  parameter int CNT_W    = 4
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_start,
  input  logic i_div,
  input  logic i_kill,
  output logic o_busy
);

  logic [CNT_W-1:0] cnt;

  // A start killed by Req never loads; an in-flight count keeps running.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt <= '0;
    end else if (i_start && !i_kill) begin
      cnt <= i_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign o_busy = i_start | (cnt != '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central F/D/E/M/W sequencer: advance, stall at D, or Req flush.
// Combines data, MDU and eret hazards; Req always wins.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_D,
  parameter int DIV_LAT  = DIV_LAT_D,
  parameter int CNT_W    = 4,
  parameter int PERF_W   = 32
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic [4:0]        i_d_rs,
  input  logic [4:0]        i_d_rt,
  input  logic [1:0]        i_d_tuse_rs,
  input  logic [1:0]        i_d_tuse_rt,
  input  logic              i_d_is_md,
  input  logic              i_d_eret,
  input  logic [4:0]        i_e_wa,
  input  logic [1:0]        i_e_tnew,
  input  logic [4:0]        i_m_wa,
  input  logic [1:0]        i_m_tnew,
  input  logic              i_e_md_start,
  input  logic              i_e_md_div,
  input  logic              i_e_mtc0_epc,
  input  logic              i_m_mtc0_epc,
  input  logic              i_int_req,
  output logic              o_pc_en,
  output logic              o_fd_en,
  output logic              o_de_flush,
  output logic              o_req,
  output logic              o_md_busy,
  output logic [1:0]        o_state,
  output logic [PERF_W-1:0] o_stall_cnt
);

  state_t state, state_n;
  logic   rs_haz, rt_haz, md_haz, eret_haz, stall;

  md_busy_timer #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT),
    .CNT_W    (CNT_W)
  ) u_md_busy_timer (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_start   (i_e_md_start),
    .i_div     (i_e_md_div),
    .i_kill    (i_int_req),
    .o_busy    (o_md_busy)
  );

  assign rs_haz =
    src_hazard(i_d_rs, i_d_tuse_rs, i_e_wa, i_e_tnew) |
    src_hazard(i_d_rs, i_d_tuse_rs, i_m_wa, i_m_tnew);
  assign rt_haz =
    src_hazard(i_d_rt, i_d_tuse_rt, i_e_wa, i_e_tnew) |
    src_hazard(i_d_rt, i_d_tuse_rt, i_m_wa, i_m_tnew);
  assign md_haz   = i_d_is_md & o_md_busy;
  assign eret_haz = i_d_eret & (i_e_mtc0_epc | i_m_mtc0_epc);
  assign stall    = rs_haz | rt_haz | md_haz | eret_haz;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= S_RUN;
    end else begin
      state <= state_n;
    end
  end

  // Next state depends only on this cycle's action, so code 3 recovers.
  always_comb begin
    state_n    = S_RUN;
    o_pc_en    = 1'b1;
    o_fd_en    = 1'b1;
    o_de_flush = 1'b0;
    o_req      = 1'b0;
    unique case (1'b1)
      i_int_req: begin
        o_req   = 1'b1;
        state_n = S_REQ;
      end
      (stall && !i_int_req): begin
        o_pc_en    = 1'b0;
        o_fd_en    = 1'b0;
        o_de_flush = 1'b1;
        state_n    = S_STALL;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_stall_cnt <= '0;
    end else if (stall && !i_int_req) begin
      o_stall_cnt <= o_stall_cnt + PERF_W'(1);
    end
  end

  assign o_state = state;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl.
// Directed scenarios plus random traffic against a behavioural model.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  d_rs, d_rt, e_wa, m_wa;
  logic [1:0]  tuse_rs, tuse_rt, e_tnew, m_tnew;
  logic        d_is_md, d_eret, e_md_start, e_md_div;
  logic        e_epc, m_epc, int_req;
  logic        pc_en, fd_en, de_flush, req, md_busy;
  logic [1:0]  state;
  logic [31:0] stall_cnt;

  int n_cmp = 0;
  int n_err = 0;

  int          m_cnt;
  int          m_state;
  logic [31:0] m_stalls;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .i_d_rs       (d_rs),
    .i_d_rt       (d_rt),
    .i_d_tuse_rs  (tuse_rs),
    .i_d_tuse_rt  (tuse_rt),
    .i_d_is_md    (d_is_md),
    .i_d_eret     (d_eret),
    .i_e_wa       (e_wa),
    .i_e_tnew     (e_tnew),
    .i_m_wa       (m_wa),
    .i_m_tnew     (m_tnew),
    .i_e_md_start (e_md_start),
    .i_e_md_div   (e_md_div),
    .i_e_mtc0_epc (e_epc),
    .i_m_mtc0_epc (m_epc),
    .i_int_req    (int_req),
    .o_pc_en      (pc_en),
    .o_fd_en      (fd_en),
    .o_de_flush   (de_flush),
    .o_req        (req),
    .o_md_busy    (md_busy),
    .o_state      (state),
    .o_stall_cnt  (stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic bit hz(input int x, input int tu,
                            input int wa, input int tn);
    return (x != 0) && (x == wa) && (tu < tn);
  endfunction

  function automatic bit m_busy();
    return (e_md_start === 1'b1) || (m_cnt > 0);
  endfunction

  function automatic bit m_stall();
    bit data;
    data = hz(d_rs, tuse_rs, e_wa, e_tnew) ||
           hz(d_rs, tuse_rs, m_wa, m_tnew) ||
           hz(d_rt, tuse_rt, e_wa, e_tnew) ||
           hz(d_rt, tuse_rt, m_wa, m_tnew);
    return data || (d_is_md && m_busy()) ||
           (d_eret && (e_epc || m_epc));
  endfunction

  task automatic idle();
    d_rs = 0; d_rt = 0; tuse_rs = 3; tuse_rt = 3;
    e_wa = 0; e_tnew = 0; m_wa = 0; m_tnew = 0;
    d_is_md = 0; d_eret = 0; e_md_start = 0; e_md_div = 0;
    e_epc = 0; m_epc = 0; int_req = 0;
  endtask

  task automatic m_reset();
    m_cnt = 0; m_state = 0; m_stalls = 0;
  endtask

  // Check against model, cross one rising edge, land on the next negedge.
  task automatic cyc();
    bit s, r;
    #1;
    s = m_stall();
    r = int_req;
    chk("pc_en", {31'd0, pc_en}, {31'd0, r || !s});
    chk("fd_en", {31'd0, fd_en}, {31'd0, r || !s});
    chk("flush", {31'd0, de_flush}, {31'd0, !r && s});
    chk("req", {31'd0, req}, {31'd0, r});
    chk("busy", {31'd0, md_busy}, {31'd0, m_busy()});
    chk("state", {30'd0, state}, 32'(m_state));
    chk("stall_cnt", stall_cnt, m_stalls);
    @(posedge clk);
    if (rst_n) begin
      if (e_md_start && !r) m_cnt = e_md_div ? 10 : 5;
      else if (m_cnt > 0) m_cnt--;
      m_state = r ? 2 : (s ? 1 : 0);
      if (s && !r) m_stalls++;
    end
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] snap;
    idle();
    m_reset();
    rst_n = 0;
    @(negedge clk);
    repeat (3) cyc();
    chk("rst_state", {30'd0, state}, 0);
    chk("rst_cnt", stall_cnt, 0);
    rst_n = 1;

    // load-use through E then M
    d_rs = 5; tuse_rs = 0; e_wa = 5; e_tnew = 2;
    cyc();
    chk("lu_st1", {30'd0, state}, 1);
    e_wa = 0; e_tnew = 0; m_wa = 5; m_tnew = 1;
    cyc();
    chk("lu_st2", {30'd0, state}, 1);
    idle();
    cyc();
    chk("lu_st3", {30'd0, state}, 0);
    chk("lu_cnt", stall_cnt, 2);

    // register zero never hazards
    d_rs = 0; tuse_rs = 0; e_wa = 0; e_tnew = 2;
    #1 chk("r0_fd_en", {31'd0, fd_en}, 1);
    cyc();

    // div then mult with mflo waiting in D
    for (int k = 0; k < 2; k++) begin
      int lat;
      lat = (k == 0) ? 10 : 5;
      idle();
      e_md_start = 1; e_md_div = (k == 0);
      #1 chk("md_t0_busy", {31'd0, md_busy}, 1);
      cyc();
      idle();
      d_is_md = 1;
      for (int t = 1; t <= lat; t++) begin
        #1 chk("md_flush", {31'd0, de_flush}, 1);
        cyc();
      end
      #1 chk("md_release", {31'd0, fd_en}, 1);
      cyc();
    end

    // Req beats stall and drops the MDU start
    idle();
    snap = m_stalls;
    d_rs = 5; tuse_rs = 0; e_wa = 5; e_tnew = 2;
    e_md_start = 1; int_req = 1;
    #1 chk("irq_req", {31'd0, req}, 1);
    chk("irq_pc", {31'd0, pc_en}, 1);
    chk("irq_flush", {31'd0, de_flush}, 0);
    cyc();
    idle();
    #1 chk("irq_state", {30'd0, state}, 2);
    chk("irq_busy", {31'd0, md_busy}, 0);
    chk("irq_cnt", stall_cnt, snap);
    cyc();

    // eret vs EPC writes
    snap = m_stalls;
    d_eret = 1; m_epc = 1;
    cyc();
    m_epc = 0;
    cyc();
    chk("eret_m", m_stalls - snap, 1);
    snap = m_stalls;
    e_epc = 1;
    cyc();
    e_epc = 0; m_epc = 1;
    cyc();
    m_epc = 0;
    cyc();
    chk("eret_e", stall_cnt - snap, 2);

    // async reset in the middle of a div
    idle();
    e_md_start = 1; e_md_div = 1;
    cyc();
    idle();
    cyc();
    #2 rst_n = 0;
    m_reset();
    #1 chk("areset_busy", {31'd0, md_busy}, 0);
    chk("areset_state", {30'd0, state}, 0);
    @(negedge clk);
    cyc();
    rst_n = 1;

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      d_rs = 5'($urandom_range(0, 3));
      d_rt = 5'($urandom_range(0, 3));
      e_wa = 5'($urandom_range(0, 3));
      m_wa = 5'($urandom_range(0, 3));
      tuse_rs = 2'($urandom_range(0, 3));
      tuse_rt = 2'($urandom_range(0, 3));
      e_tnew = 2'($urandom_range(0, 3));
      m_tnew = 2'($urandom_range(0, 3));
      d_is_md = ($urandom_range(0, 3) == 0);
      d_eret = ($urandom_range(0, 7) == 0);
      e_md_start = ($urandom_range(0, 9) == 0);
      e_md_div = $urandom_range(0, 1) == 1;
      e_epc = ($urandom_range(0, 3) == 0);
      m_epc = ($urandom_range(0, 3) == 0);
      int_req = ($urandom_range(0, 15) == 0);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
